// File: rtl/dump_seq_pkg.sv
// Shared types and word-address list for the correlator state-dump sequencer.
// The accumulator base address is used only when DUMP_SEQ_ACC_EN is defined.
package dump_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WRITE,
    ST_ACK
  } dump_state_e;

  localparam int unsigned CORE_LEN = 9;
  localparam logic [4:0]  ACC_BASE = 5'd16;

  // Address 14 is not part of the channel state and is skipped.
  localparam logic [4:0] CORE_ADDR [CORE_LEN] = '{
    5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd15
  };

  function automatic logic [4:0] word_addr(input logic [4:0] idx);
    if (idx < 5'(CORE_LEN)) begin
      return CORE_ADDR[idx[3:0]];
    end
    return ACC_BASE + (idx - 5'(CORE_LEN));
  endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin arbiter: first unmasked requester at or
// after i_ptr in cyclic order 0->3 wins; grant is one-hot plus its index.
module rr_arbiter_4 (
  input  logic [3:0] i_req,
  input  logic [3:0] i_mask,
  input  logic [1:0] i_ptr,
  output logic [3:0] o_grant,
  output logic [1:0] o_grant_idx,
  output logic       o_valid
);

  logic [3:0] w_eff;

  assign w_eff = i_req & ~i_mask;

  always_comb begin
    logic [1:0] v_idx;
    // NOTE: every output gets a default first, so no path leaves a latch behind.
    o_grant     = '0;
    o_grant_idx = '0;
    o_valid     = 1'b0;
    v_idx       = '0;
    // Walk from the farthest offset down so the nearest requester overwrites last.
    for (int k = 3; k >= 0; k--) begin
      v_idx = i_ptr + 2'(k);
      if (w_eff[v_idx]) begin
        o_grant     = 4'b0001 << v_idx;
        o_grant_idx = v_idx;
        o_valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dump_sequencer.sv
// Round-robin dump of four physical correlator channels into the state buffer.
// Define DUMP_SEQ_ACC_EN to append COR_NUM accumulator words (16..) per dump.
module dump_sequencer
  import dump_seq_pkg::*;
#(
  parameter int unsigned LCH_W   = 5,
  parameter int unsigned COR_NUM = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           dump_req,
  input  logic [4*LCH_W-1:0]   logic_ch_map,
  output logic [3:0]           dump_ack,
  output logic                 busy,
  output logic [1:0]           physical_channel_index,
  output logic [4:0]           state_addr,
  input  logic [31:0]          state_d4wt,
  output logic                 buf_req,
  input  logic                 buf_grant,
  output logic [LCH_W+4:0]     buf_addr,
  output logic [31:0]          buf_wdata
);

  localparam int unsigned MAX_WORDS = CORE_LEN + COR_NUM;
  localparam int unsigned IDX_W     = $clog2(MAX_WORDS + 2);
`ifdef DUMP_SEQ_ACC_EN
  localparam int unsigned N_WORDS   = CORE_LEN + COR_NUM;
`else
  localparam int unsigned N_WORDS   = CORE_LEN;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  dump_state_e      r_state;
  logic [1:0]       r_rr_ptr;
  logic [3:0]       r_ch_oh;
  logic [3:0]       r_mask;
  logic [LCH_W-1:0] r_lch;
  logic [IDX_W-1:0] r_widx;
  logic [3:0]       r_dump_ack;
  logic             r_busy;
  logic [1:0]       r_pci;
  logic [4:0]       r_state_addr;
  logic             r_buf_req;
  logic [LCH_W+4:0] r_buf_addr;

  logic [3:0]       w_grant;
  logic [1:0]       w_gnt_idx;
  logic             w_gnt_valid;
  logic [LCH_W-1:0] w_map [4];
  logic [IDX_W-1:0] w_idx_p1;
  logic [IDX_W-1:0] w_idx_p2;

  for (genvar k = 0; k < 4; k++) begin : g_map
    assign w_map[k] = logic_ch_map[k*LCH_W +: LCH_W];
  end

  assign w_idx_p1 = r_widx + IDX_W'(1);
  assign w_idx_p2 = r_widx + IDX_W'(2);

  rr_arbiter_4 u_arb (
    .i_req       (dump_req),
    .i_mask      (r_mask),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_gnt_idx),
    .o_valid     (w_gnt_valid)
  );

  // The mux output is registered, so state_addr runs one word ahead of
  // buf_addr: the data on state_d4wt belongs to the word now in buf_addr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_ch_oh      <= '0;
      r_mask       <= '0;
      r_lch        <= '0;
      r_widx       <= '0;
      r_dump_ack   <= '0;
      r_busy       <= 1'b0;
      r_pci        <= '0;
      r_state_addr <= '0;
      r_buf_req    <= 1'b0;
      r_buf_addr   <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads pre-edge state.
      r_dump_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          r_mask <= '0;
          if (w_gnt_valid) begin
            r_ch_oh      <= w_grant;
            r_pci        <= w_gnt_idx;
            r_lch        <= w_map[w_gnt_idx];
            r_widx       <= '0;
            r_state_addr <= word_addr(5'd0);
            r_busy       <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          r_buf_req    <= 1'b1;
          r_buf_addr   <= {r_lch, r_state_addr};
          r_state_addr <= word_addr(5'd1);
          r_state      <= ST_WRITE;
        end

        ST_WRITE: begin
          if (buf_grant) begin
            if (r_widx == LAST_IDX) begin
              r_buf_req  <= 1'b0;
              r_dump_ack <= r_ch_oh;
              r_state    <= ST_ACK;
            end else begin
              r_widx     <= w_idx_p1;
              r_buf_addr <= {r_lch, r_state_addr};
              // No prefetch past the list end; state_addr parks on the last word.
              if (w_idx_p2 <= LAST_IDX) begin
                r_state_addr <= word_addr(5'(w_idx_p2));
              end
            end
          end
        end

        ST_ACK: begin
          r_busy   <= 1'b0;
          r_mask   <= r_ch_oh;
          r_rr_ptr <= r_pci + 2'd1;
          r_state  <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dump_ack               = r_dump_ack;
  assign busy                   = r_busy;
  assign physical_channel_index = r_pci;
  assign state_addr             = r_state_addr;
  assign buf_req                = r_buf_req;
  assign buf_addr               = r_buf_addr;
  assign buf_wdata              = state_d4wt;

endmodule

// File: tb/tb_dump_sequencer.sv
// Directed bench for dump_sequencer: table of single-channel dumps plus
// hand-written arbitration, stall and mid-dump reset sequences.
module tb_dump_sequencer;

  localparam int LCH_W = 5;
`ifdef DUMP_SEQ_ACC_EN
  localparam int N_WORDS = 9 + 8;
`else
  localparam int N_WORDS = 9;
`endif

  logic               clk;
  logic               rst;
  logic [3:0]         dump_req;
  logic [4*LCH_W-1:0] logic_ch_map;
  logic [3:0]         dump_ack;
  logic               busy;
  logic [1:0]         physical_channel_index;
  logic [4:0]         state_addr;
  logic [31:0]        state_d4wt;
  logic               buf_req;
  logic               buf_grant;
  logic [LCH_W+4:0]   buf_addr;
  logic [31:0]        buf_wdata;

  int n_vec = 0;
  int n_err = 0;

  logic [4:0] exp_word [32];

  typedef struct {
    logic [3:0]         req;
    logic [4*LCH_W-1:0] map;
    logic [1:0]         ch;
    logic [LCH_W-1:0]   exp_lch;
    logic [3:0]         exp_ack;
  } vec_t;

  vec_t vecs [4];

  dump_sequencer #(.LCH_W(LCH_W), .COR_NUM(8)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .dump_req               (dump_req),
    .logic_ch_map           (logic_ch_map),
    .dump_ack               (dump_ack),
    .busy                   (busy),
    .physical_channel_index (physical_channel_index),
    .state_addr             (state_addr),
    .state_d4wt             (state_d4wt),
    .buf_req                (buf_req),
    .buf_grant              (buf_grant),
    .buf_addr               (buf_addr),
    .buf_wdata              (buf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mux_val(input logic [1:0] ch, input logic [4:0] a);
    return {8'hD0, 6'd0, ch, 11'd0, a};
  endfunction

  // Dump-state mux model: registered, one cycle behind its select inputs.
  always @(posedge clk) state_d4wt <= mux_val(physical_channel_index, state_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},  32'(dump_ack), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_breq"}, 32'(buf_req), 32'd0);
    check({tag, "_pci"},  32'(physical_channel_index), 32'd0);
    check({tag, "_saddr"}, 32'(state_addr), 32'd0);
    check({tag, "_baddr"}, 32'(buf_addr), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dump_req = '0;
    buf_grant = 1'b1;
    tick();
    tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();
  endtask

  // Caller has driven the request during cycle 0 (an IDLE cycle). Returns
  // in the ack cycle.
  task automatic run_dump(input logic [1:0] ch, input logic [LCH_W-1:0] lch,
                          input logic [3:0] exp_ack, input int stall_at, input int stall_len);
    int nw;
    int stall_left;
    bit done;
    logic [4:0] frz_saddr;
    nw = 0;
    stall_left = stall_len;
    done = 1'b0;
    frz_saddr = '0;
    tick();
    check("issue_busy", 32'(busy), 32'd1);
    check("issue_pci", 32'(physical_channel_index), 32'(ch));
    check("issue_saddr", 32'(state_addr), 32'(exp_word[0]));
    for (int cyc = 1; cyc < 80 && !done; cyc++) begin
      buf_grant = 1'b1;
      if (buf_req) begin
        check("wr_addr", 32'(buf_addr), 32'({lch, exp_word[nw]}));
        if (nw == stall_at && stall_left > 0) begin
          if (stall_left == stall_len) frz_saddr = state_addr;
          else check("stall_saddr", 32'(state_addr), 32'(frz_saddr));
          buf_grant = 1'b0;
          stall_left--;
        end else begin
          if (stall_len == 0) check("wr_data", buf_wdata, mux_val(ch, exp_word[nw]));
          nw++;
        end
      end
      if (dump_ack != 4'd0) begin
        check("ack_onehot", 32'(dump_ack), 32'(exp_ack));
        check("ack_cycle", 32'(cyc), 32'(N_WORDS + 2 + stall_len));
        check("ack_nwrites", 32'(nw), 32'(N_WORDS));
        check("ack_busy", 32'(busy), 32'd1);
        done = 1'b1;
      end else begin
        tick();
      end
    end
    if (!done) check("ack_timeout", 32'(dump_ack), 32'(exp_ack));
    buf_grant = 1'b1;
  endtask

  initial begin
    int core_list [9] = '{6, 7, 8, 9, 10, 11, 12, 13, 15};
    for (int i = 0; i < 32; i++) exp_word[i] = '0;
    for (int i = 0; i < 9; i++) exp_word[i] = 5'(core_list[i]);
    for (int i = 9; i < N_WORDS; i++) exp_word[i] = 5'(16 + i - 9);

    // map is {ch3, ch2, ch1, ch0}
    vecs[0] = '{4'b0100, {5'd4,  5'd7, 5'd2,  5'd1},  2'd2, 5'd7,  4'b0100};
    vecs[1] = '{4'b0001, {5'd9,  5'd8, 5'd3,  5'd0},  2'd0, 5'd0,  4'b0001};
    vecs[2] = '{4'b1000, {5'd31, 5'd1, 5'd2,  5'd3},  2'd3, 5'd31, 4'b1000};
    vecs[3] = '{4'b0010, {5'd0,  5'd5, 5'd16, 5'd30}, 2'd1, 5'd16, 4'b0010};

    rst = 1'b1;
    dump_req = '0;
    logic_ch_map = '0;
    buf_grant = 1'b1;
    do_reset();

    // Single-channel dumps with continuous grant.
    for (int v = 0; v < 4; v++) begin
      logic_ch_map = vecs[v].map;
      dump_req = vecs[v].req;
      run_dump(vecs[v].ch, vecs[v].exp_lch, vecs[v].exp_ack, -1, 0);
      dump_req = '0;
      tick();
      tick();
      check("post_idle_busy", 32'(busy), 32'd0);
    end

    // All four together from rr_ptr 0: ch0..ch3 in order, ack before next grant.
    do_reset();
    logic_ch_map = {5'd13, 5'd12, 5'd11, 5'd10};
    dump_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      run_dump(2'(i), 5'(10 + i), 4'b0001 << i, -1, 0);
      dump_req[i] = 1'b0;
      if (i < 3) begin
        tick();
        check("all4_gap_busy", 32'(busy), 32'd0);
      end
    end
    tick();
    tick();

    // Grant withheld 3 cycles on word 4: frozen addresses, ack 3 cycles later.
    logic_ch_map = {5'd4, 5'd7, 5'd2, 5'd1};
    dump_req = 4'b0100;
    run_dump(2'd2, 5'd7, 4'b0100, 4, 3);
    dump_req = '0;
    tick();
    tick();

    // Ch1 holds its request after ack while ch3 requests: ch3 goes next.
    do_reset();
    logic_ch_map = {5'd21, 5'd20, 5'd19, 5'd18};
    dump_req = 4'b1010;
    run_dump(2'd1, 5'd19, 4'b0010, -1, 0);
    tick();
    check("rr_gap_busy", 32'(busy), 32'd0);
    run_dump(2'd3, 5'd21, 4'b1000, -1, 0);
    dump_req[3] = 1'b0;
    tick();
    run_dump(2'd1, 5'd19, 4'b0010, -1, 0);
    // Lone held request: ignored in the ACK cycle and the next IDLE cycle.
    tick();
    check("mask_idle1_busy", 32'(busy), 32'd0);
    tick();
    check("mask_idle2_busy", 32'(busy), 32'd0);
    run_dump(2'd1, 5'd19, 4'b0010, -1, 0);
    dump_req = '0;
    tick();
    tick();

    // Reset on the fifth write, then a fresh dump from word 0.
    do_reset();
    logic_ch_map = {5'd0, 5'd0, 5'd0, 5'd3};
    dump_req = 4'b0001;
    for (int c = 1; c <= 6; c++) tick();
    check("w5_breq", 32'(buf_req), 32'd1);
    check("w5_baddr", 32'(buf_addr), 32'({5'd3, 5'd10}));
    #1 rst = 1'b1;
    dump_req = '0;
    #1 check_reset_outputs("midrst");
    tick();
    check("midrst_noack", 32'(dump_ack), 32'd0);
    rst = 1'b0;
    tick();
    check("after_rst_ack", 32'(dump_ack), 32'd0);
    check("after_rst_busy", 32'(busy), 32'd0);
    dump_req = 4'b0001;
    run_dump(2'd0, 5'd3, 4'b0001, -1, 0);
    dump_req = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule
